// File: rtl/dsa_cmd_pkg.sv
// Shared definitions for the DSA 16-bit command-word protocol.
// Used by both the command master and the command decoder.
package dsa_cmd_pkg;

    localparam logic [3:0] TYPE_NOP       = 4'd0;
    localparam logic [3:0] TYPE_WRITE_REG = 4'd1;
    localparam logic [3:0] TYPE_READ_REG  = 4'd2;
    localparam logic [3:0] TYPE_WRITE_MEM = 4'd3;
    localparam logic [3:0] TYPE_READ_MEM  = 4'd4;

    typedef enum logic [3:0] {
        REG_0        = 4'd0,
        REG_1        = 4'd1,
        REG_2        = 4'd2,
        REG_3        = 4'd3,
        REG_4        = 4'd4,
        REG_5        = 4'd5,
        REG_6        = 4'd6,
        REG_7        = 4'd7,
        REG_8        = 4'd8,
        REG_9        = 4'd9,
        REG_10       = 4'd10,
        REG_MEM_DATA = 4'd11,
        REG_12       = 4'd12,
        REG_13       = 4'd13,
        REG_14       = 4'd14,
        REG_15       = 4'd15
    } reg_addr_e;

    typedef enum logic [1:0] {
        OP_WRITE_REG = 2'd0,
        OP_READ_REG  = 2'd1,
        OP_WRITE_MEM = 2'd2,
        OP_READ_MEM  = 2'd3
    } req_op_e;

    function automatic logic [15:0] encode_cmd(input logic [3:0] addr,
                                               input logic [3:0] cmd_type,
                                               input logic [7:0] data);
        return {addr, cmd_type, data};
    endfunction

    localparam logic [15:0] CMD_NOP    = 16'h0000;
    localparam logic [15:0] CMD_MEM_RD = {4'(REG_MEM_DATA), TYPE_READ_REG, 8'h00};

endpackage

// File: rtl/dsa_cmd_master.sv
// On-chip initiator for the DSA command-word protocol: encodes transactions,
// holds each word, inserts NOP separators and captures read-back data.
module dsa_cmd_master
    import dsa_cmd_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int RD_LAT      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [3:0]  req_reg,
    input  logic [7:0]  req_data,
    output logic [15:0] cmd_word,
    input  logic [15:0] rd_word,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic [15:0] words_sent,
    output logic [15:0] seps_sent
);

    localparam int CNT_MAX = (HOLD_CYCLES > RD_LAT) ? HOLD_CYCLES : RD_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEP,
        ST_ISSUE,
        ST_ISSUE2,
        ST_RDWAIT
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       cmd_q, cmd_d;
    logic [15:0]       pend_q, pend_d;
    req_op_e           op_q, op_d;
    logic              second_q, second_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [7:0]        rsp_data_q, rsp_data_d;
    logic [15:0]       words_q, words_d;
    logic [15:0]       seps_q, seps_d;

    logic              load;
    logic [15:0]       load_word;
    logic              load_second;
    logic              rd_exit;
    logic [15:0]       first_word;
    logic              unused_rd_hi;

    assign unused_rd_hi = ^rd_word[15:8];

    always_comb begin
        first_word = CMD_NOP;
        case (req_op_e'(req_op))
            OP_WRITE_REG: first_word = encode_cmd(req_reg, TYPE_WRITE_REG, req_data);
            OP_READ_REG:  first_word = encode_cmd(req_reg, TYPE_READ_REG, 8'h00);
            OP_WRITE_MEM: first_word = encode_cmd(4'h0, TYPE_WRITE_MEM, req_data);
            OP_READ_MEM:  first_word = encode_cmd(4'h0, TYPE_READ_MEM, 8'h00);
            default:      first_word = CMD_NOP;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        pend_d      = pend_q;
        op_d        = op_q;
        second_d    = second_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        words_d     = words_q;
        seps_d      = seps_q;
        load        = 1'b0;
        load_word   = CMD_NOP;
        load_second = 1'b0;
        rd_exit     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d      = req_op_e'(req_op);
                    load      = 1'b1;
                    load_word = first_word;
                end
            end
            ST_SEP: begin
                if (cnt_q == HOLD_LAST) begin
                    load        = 1'b1;
                    load_word   = pend_q;
                    load_second = second_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ISSUE: begin
                if (cnt_q == HOLD_LAST) begin
                    case (op_q)
                        OP_READ_REG: rd_exit = 1'b1;
                        OP_READ_MEM: begin
                            load        = 1'b1;
                            load_word   = CMD_MEM_RD;
                            load_second = 1'b1;
                        end
                        default:     state_d = ST_IDLE;
                    endcase
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ISSUE2: begin
                if (cnt_q == HOLD_LAST) begin
                    rd_exit = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RDWAIT: begin
                if (cnt_q >= RD_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rd_word[7:0];
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Read latency is counted from visibility of the read word, so the
        // hold count carries straight on into the wait.
        if (rd_exit) begin
            if (RD_LAT <= HOLD_CYCLES) begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = rd_word[7:0];
                state_d     = ST_IDLE;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                state_d = ST_RDWAIT;
            end
        end

        // The decoder only acts on a change, so a repeated word is preceded by a NOP.
        if (load) begin
            cnt_d    = '0;
            words_d  = words_q + 16'd1;
            second_d = load_second;
            if (load_word == cmd_q) begin
                cmd_d   = CMD_NOP;
                pend_d  = load_word;
                seps_d  = seps_q + 16'd1;
                state_d = ST_SEP;
            end else begin
                cmd_d   = load_word;
                state_d = load_second ? ST_ISSUE2 : ST_ISSUE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_q       <= CMD_NOP;
            pend_q      <= CMD_NOP;
            op_q        <= OP_WRITE_REG;
            second_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            words_q     <= 16'd0;
            seps_q      <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            pend_q      <= pend_d;
            op_q        <= op_d;
            second_q    <= second_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            words_q     <= words_d;
            seps_q      <= seps_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE) && !rst;
    assign cmd_word   = cmd_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign words_sent = words_q;
    assign seps_sent  = seps_q;

endmodule

// File: tb/tb_dsa_cmd_master.sv
// Bench for dsa_cmd_master: a small decoder/memory environment plus a
// transaction-level reference of register/memory contents and word sequences.
module tb_dsa_cmd_master;

    localparam int HOLD = 4;
    localparam int RDL  = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [3:0]  req_reg;
    logic [7:0]  req_data;
    logic [15:0] cmd_word;
    logic [15:0] rd_word;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic [15:0] words_sent;
    logic [15:0] seps_sent;

    int checks   = 0;
    int failures = 0;

    // Environment: decoder with register file and byte memory.
    logic [7:0]  dec_regs [16];
    logic [7:0]  dec_mem  [65536];
    logic [3:0]  dec_sel;
    logic [15:0] dec_prev;

    // Reference: what the decoder state should be after each transaction.
    logic [7:0]  ref_regs [16];
    logic [7:0]  ref_mem  [65536];
    logic [15:0] ref_last;
    logic [15:0] ref_words;
    logic [15:0] ref_seps;
    int          txn_no = 0;

    dsa_cmd_master #(.HOLD_CYCLES(HOLD), .RD_LAT(RDL)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_reg    (req_reg),
        .req_data   (req_data),
        .cmd_word   (cmd_word),
        .rd_word    (rd_word),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .words_sent (words_sent),
        .seps_sent  (seps_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        dec_prev <= cmd_word;
        rd_word  <= {8'h00, dec_regs[dec_sel]};
        if (cmd_word != dec_prev) begin
            case (cmd_word[11:8])
                4'd1: dec_regs[cmd_word[15:12]] <= cmd_word[7:0];
                4'd2: dec_sel <= cmd_word[15:12];
                4'd3: dec_mem[{dec_regs[10], dec_regs[9]}] <= cmd_word[7:0];
                4'd4: dec_regs[11] <= dec_mem[{dec_regs[10], dec_regs[9]}];
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_txn(input logic [1:0] op, input logic [3:0] rg, input logic [7:0] dt);
        logic [15:0] words[$];
        logic [15:0] seq[$];
        logic [15:0] exp_cmd;
        logic [15:0] maddr;
        logic [7:0]  exp_data;
        logic        is_rd;
        int          total, rsp_edge, done, guard, idx;

        exp_data = 8'h00;
        maddr    = {ref_regs[10], ref_regs[9]};
        case (op)
            2'd0: begin words.push_back({rg, 4'h1, dt}); ref_regs[rg] = dt; end
            2'd1: begin words.push_back({rg, 4'h2, 8'h00}); exp_data = ref_regs[rg]; end
            2'd2: begin words.push_back({4'h0, 4'h3, dt}); ref_mem[maddr] = dt; end
            default: begin
                words.push_back(16'h0400);
                words.push_back(16'hB200);
                ref_regs[11] = ref_mem[maddr];
                exp_data = ref_regs[11];
            end
        endcase
        foreach (words[i]) begin
            if (words[i] == ref_last) begin
                seq.push_back(16'h0000);
                ref_seps++;
            end
            seq.push_back(words[i]);
            ref_last = words[i];
        end
        ref_words += 16'(seq.size());
        is_rd    = op[0];
        total    = seq.size() * HOLD;
        rsp_edge = total - HOLD + RDL;
        done     = is_rd ? rsp_edge : total;

        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_wait", {15'd0, req_ready}, 16'd1);

        req_valid = 1'b1;
        req_op    = op;
        req_reg   = rg;
        req_data  = dt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;

        for (int j = 0; j <= done; j++) begin
            idx     = j / HOLD;
            exp_cmd = (idx < seq.size()) ? seq[idx] : seq[seq.size() - 1];
            chk("cmd_word", cmd_word, exp_cmd);
            chk("rsp_valid", {15'd0, rsp_valid}, {15'd0, (is_rd && j == rsp_edge)});
            if (is_rd && j == rsp_edge)
                chk("rsp_data", {8'h00, rsp_data}, {8'h00, exp_data});
            chk("req_ready", {15'd0, req_ready}, {15'd0, (j >= done)});
            if (j < done) begin
                @(posedge clk);
                #1;
            end
        end
        chk("words_sent", words_sent, ref_words);
        chk("seps_sent", seps_sent, ref_seps);
        txn_no++;
        $display("txn %0d op=%0d reg=%h data=%h words=%0d rsp=%h", txn_no, op, rg, dt,
                 seq.size(), rsp_data);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_reg   = 4'h0;
        req_data  = 8'h00;
        rd_word   = 16'h0000;
        dec_sel   = 4'h0;
        dec_prev  = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            dec_regs[i] = 8'(8'h30 + i);
            ref_regs[i] = 8'(8'h30 + i);
        end
        dec_regs[6] = 8'h02;
        ref_regs[6] = 8'h02;
        for (int i = 0; i < 65536; i++) begin
            dec_mem[i] = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        ref_last  = 16'h0000;
        ref_words = 16'd0;
        ref_seps  = 16'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd", cmd_word, 16'h0000);
        chk("rst_ready", {15'd0, req_ready}, 16'd0);
        chk("rst_rsp_valid", {15'd0, rsp_valid}, 16'd0);
        chk("rst_rsp_data", {8'h00, rsp_data}, 16'h0000);
        chk("rst_words", words_sent, 16'd0);
        chk("rst_seps", seps_sent, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed steps
        do_txn(2'd0, 4'd5, 8'h40);
        do_txn(2'd2, 4'd0, 8'hAA);
        do_txn(2'd2, 4'd0, 8'hAA);
        do_txn(2'd1, 4'd6, 8'h00);
        do_txn(2'd0, 4'd9, 8'h10);
        do_txn(2'd0, 4'd10, 8'h00);
        dec_mem[16'h0010] = 8'h7C;
        ref_mem[16'h0010] = 8'h7C;
        do_txn(2'd3, 4'd0, 8'h00);
        chk("mem_read_value", {8'h00, rsp_data}, 16'h007C);
        do_txn(2'd1, 4'd6, 8'h00);
        do_txn(2'd1, 4'd6, 8'h00);
        do_txn(2'd3, 4'd0, 8'h00);
        do_txn(2'd3, 4'd0, 8'h00);

        // Reset during the read wait of a READ_REG
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_reg   = 4'd3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_cmd", cmd_word, 16'h0000);
        chk("midrst_ready", {15'd0, req_ready}, 16'd0);
        chk("midrst_words", words_sent, 16'd0);
        chk("midrst_seps", seps_sent, 16'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("midrst_no_rsp", {15'd0, rsp_valid}, 16'd0);
        end
        rst       = 1'b0;
        ref_last  = 16'h0000;
        ref_words = 16'd0;
        ref_seps  = 16'd0;
        @(posedge clk);
        #1;
        chk("postrst_ready", {15'd0, req_ready}, 16'd1);
        chk("postrst_no_rsp", {15'd0, rsp_valid}, 16'd0);

        // Randomized transactions against the reference
        for (int t = 0; t < 30; t++) begin
            do_txn(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                   8'($urandom_range(0, 255)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dsa_cmd_master.md
# dsa_cmd_master

On-chip initiator for the DSA 16-bit command-word protocol; it drives the same word that the PC-side Virtual JTAG path normally drives into the command decoder. It accepts high-level register and memory transactions and emits encoded command words with the required hold time. Consecutive identical words are separated by an inserted NOP, because the decoder only acts when the word changes. Read-back data is captured from the decoder's read mux. It is used for self-test and for board bring-up without a PC.

## Interface
Parameters:
- HOLD_CYCLES, 4, clk cycles each emitted word is held stable (≥3).
- RD_LAT, 6, cycles from a read word becoming visible to sampling rd_word (≥ HOLD_CYCLES).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  transaction request.
- req_ready  out  1  high only in IDLE.
- req_op  in  2  0=WRITE_REG, 1=READ_REG, 2=WRITE_MEM, 3=READ_MEM.
- req_reg  in  4  register address; ignored for memory ops.
- req_data  in  8  write byte; ignored for reads.
- cmd_word  out  16  registered word to the decoder: {addr[3:0], type[3:0], data[7:0]}.
- rd_word  in  16  decoder read-back mux output.
- rsp_valid  out  1  one-cycle pulse with read data; no backpressure.
- rsp_data  out  8  rd_word[7:0] sampled at the rsp_valid edge.
- words_sent  out  16  count of emitted words, including separators; wraps.
- seps_sent  out  16  count of inserted NOP separators; wraps.

## Operation
- Type codes: NOP=0, WRITE_REG=1, READ_REG=2, WRITE_MEM=3, READ_MEM=4.
- Encoding per op:
  - WRITE_REG → {req_reg, 1, req_data}.
  - READ_REG → {req_reg, 2, 8'h00}.
  - WRITE_MEM → {4'h0, 3, req_data}.
  - READ_MEM → word {4'h0, 4, 8'h00}, then word 16'hB200 (READ_REG of MEM_DATA, register 11).
- Separator rule: if the next word equals the current cmd_word, first emit 16'h0000 for HOLD_CYCLES, then the real word. The rule applies to every emitted word, including the second word of READ_MEM.
- States:
  - IDLE: req_ready=1.
  - SEP: hold NOP.
  - ISSUE: hold command word.
  - ISSUE2: hold 16'hB200.
  - RDWAIT: count to RD_LAT, sample rd_word.
- Transitions:
  - IDLE + req_valid → SEP if the separator rule applies, else ISSUE.
  - SEP → ISSUE after HOLD_CYCLES.
  - ISSUE after HOLD_CYCLES: writes → IDLE; READ_REG → RDWAIT (counting continues from word visibility); READ_MEM → ISSUE2.
  - ISSUE2 → RDWAIT.
  - RDWAIT → IDLE with the rsp_valid pulse.
- Idle keeps the last word unchanged, so the decoder takes no action.
- Reset values: cmd_word=0x0000, req_ready=0 while rst is high, then 1 in IDLE. rsp_valid=0, rsp_data=0x00, counters=0, state=IDLE.
- Reset mid-transaction: the transaction is dropped and no rsp_valid is issued. The cmd_word return to 0x0000 is a NOP change, harmless to the decoder.
- Counters increment on the edge a new word is loaded.

## Timing
- Accept at edge k (req_valid & req_ready) loads the first word (or NOP) at edge k; it is visible from cycle k+1.
- Write without separator: req_ready reasserts after edge k+HOLD_CYCLES (4 cycles per write at default).
- Write with separator: NOP for cycles k+1..k+4, real word from edge k+4, req_ready again after edge k+8.
- READ_REG, no separator: rsp_valid and rsp_data are registered at edge k+RD_LAT (k+6). IDLE follows at the same edge.
- READ_MEM, no separators: READ_MEM word at edge k, 16'hB200 at edge k+HOLD_CYCLES, rsp at edge k+HOLD_CYCLES+RD_LAT (k+10).
- Decoder path, for reference of the margins: it sees the change one edge after visibility and acts on the following edge, 2 cycles total. RD_LAT=6 leaves 4 cycles of mux settle.
- Hold counter width: clog2(max(HOLD_CYCLES, RD_LAT)+1).

## Structure
- Shared package dsa_cmd_pkg holds:
  - the type-code constants;
  - the register-address enum (0–15, MEM_DATA=11);
  - the req_op enum;
  - the function encode_cmd(addr, type, data) → 16-bit word.
  - The decoder side is migrated to the same package.
- Single module; the hold/latency counter is inline. No sub-module is required.

## Test plan
- Reset then WRITE_REG reg=5 data=0x40 → cmd_word=0x5140 from cycle 1, held 4 cycles; req_ready high at cycle 5; words_sent=1.
- Two WRITE_MEM data=0xAA back-to-back → 0x03AA, 0x0000 (4 cycles), 0x03AA; seps_sent=1, words_sent=3.
- READ_REG reg=6 with rd_word model returning 0x0002 → cmd_word=0x6200; rsp_valid pulse at edge 6 with rsp_data=0x02.
- READ_MEM with decoder+memory model preloaded so address 0x00010 holds 0x7C (address set via WRITE_REG 9/10) → words 0x0400 then 0xB200; rsp_data=0x7C at edge 10.
- Two READ_REG reg=6 back-to-back → separator inserted before the second 0x6200; both rsp_valid pulses occur.
- Assert rst during RDWAIT of a READ_REG → cmd_word=0x0000 immediately, no rsp_valid, counters=0, req_ready high one cycle after rst deasserts.
